// File: rtl/life_gen_if.sv
// Control/status bundle between the generation scheduler and its producer/PE side.
// With STILL_LIFE_HALT_EN defined the bundle also carries the halted status bit.
interface life_gen_if;
    logic        frame_tick;
    logic        run;
    logic        step_btn;
    logic        load_req;
    logic [3:0]  pe_done;
    logic [63:0] alive_in;
    logic        pe_step;
    logic        pe_load;
    logic [63:0] alive_prev;
    logic [15:0] gen_count;
    logic        busy;
    logic        timeout_err;
`ifdef STILL_LIFE_HALT_EN
    logic        halted;
`endif

    modport slave (
        input  frame_tick, run, step_btn, load_req, pe_done, alive_in,
        output pe_step, pe_load, alive_prev, gen_count, busy, timeout_err
`ifdef STILL_LIFE_HALT_EN
        , output halted
`endif
    );

    modport master (
        output frame_tick, run, step_btn, load_req, pe_done, alive_in,
        input  pe_step, pe_load, alive_prev, gen_count, busy, timeout_err
`ifdef STILL_LIFE_HALT_EN
        , input halted
`endif
    );
endinterface

// File: rtl/life_gen_scheduler.sv
// Frame-paced Game-of-Life generation scheduler for four PE arrays (run/step/load, timeout).
// Optional macro STILL_LIFE_HALT_EN: stop run mode once a step leaves the board unchanged.
module life_gen_scheduler #(
    parameter int FRAMES_PER_GEN = 30,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int NUM_ARRAYS     = 4
) (
    input  logic      clk,
    input  logic      rst,
    life_gen_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]            FRAME_LAST = 8'(FRAMES_PER_GEN - 1);
    localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_ARRAYS-1:0] ALL_DONE   = '1;

    typedef enum logic [2:0] {IDLE, ARM, SNAP, WAIT_DONE, LOAD} state_e;

    state_e                state_q, state_d;
    logic                  single_q, single_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [NUM_ARRAYS-1:0] done_mask_q, done_mask_d, done_now;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [15:0]           gen_count_q, gen_count_d;
    logic [63:0]           alive_prev_q, alive_prev_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  step_pending_q, step_pending_d;
    logic                  step_btn_q;
    logic                  pe_step_q, pe_load_q;
    logic                  pend_clr, step_edge, completed, run_blocked;

    assign step_edge = bus.step_btn & ~step_btn_q;
    assign done_now  = done_mask_q | bus.pe_done;

`ifdef STILL_LIFE_HALT_EN
    logic halted_q, run_q, chk_q;
    assign run_blocked = halted_q;
    assign bus.halted  = halted_q;

    // PE outputs are registered, so the post-step board is compared one cycle after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
            run_q    <= 1'b0;
            chk_q    <= 1'b0;
        end else begin
            run_q <= bus.run;
            chk_q <= completed;
            if (state_q == LOAD || (run_q && !bus.run))
                halted_q <= 1'b0;
            else if (chk_q && bus.alive_in == alive_prev_q)
                halted_q <= 1'b1;
        end
    end
`else
    assign run_blocked = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        single_d      = single_q;
        frame_cnt_d   = frame_cnt_q;
        done_mask_d   = done_mask_q;
        tmo_d         = tmo_q;
        gen_count_d   = gen_count_q;
        alive_prev_d  = alive_prev_q;
        timeout_err_d = timeout_err_q;
        pend_clr      = 1'b0;
        completed     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    state_d = LOAD;
                end else if (bus.run && !run_blocked) begin
                    state_d  = ARM;
                    single_d = 1'b0;
                end else if (step_pending_q) begin
                    state_d  = ARM;
                    single_d = 1'b1;
                    pend_clr = 1'b1;
                end
            end
            ARM: begin
                // Dropping run keeps frame_cnt so the cadence resumes where it left off.
                if (bus.load_req) begin
                    state_d = IDLE;
                end else if (!single_q && (!bus.run || run_blocked)) begin
                    state_d = IDLE;
                end else if (bus.frame_tick) begin
                    if (single_q) begin
                        state_d = SNAP;
                    end else if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = 8'd0;
                        state_d     = SNAP;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            SNAP: begin
                alive_prev_d = bus.alive_in;
                done_mask_d  = '0;
                tmo_d        = '0;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                done_mask_d = done_now;
                if (done_now == ALL_DONE) begin
                    gen_count_d = gen_count_q + 16'd1;
                    completed   = 1'b1;
                    state_d     = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOAD: begin
                alive_prev_d  = '0;
                gen_count_d   = '0;
                frame_cnt_d   = '0;
                timeout_err_d = 1'b0;
                pend_clr      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        step_pending_d = (step_pending_q & ~pend_clr) | step_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            single_q       <= 1'b0;
            frame_cnt_q    <= '0;
            done_mask_q    <= '0;
            tmo_q          <= '0;
            gen_count_q    <= '0;
            alive_prev_q   <= '0;
            timeout_err_q  <= 1'b0;
            step_pending_q <= 1'b0;
            step_btn_q     <= 1'b0;
            pe_step_q      <= 1'b0;
            pe_load_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            single_q       <= single_d;
            frame_cnt_q    <= frame_cnt_d;
            done_mask_q    <= done_mask_d;
            tmo_q          <= tmo_d;
            gen_count_q    <= gen_count_d;
            alive_prev_q   <= alive_prev_d;
            timeout_err_q  <= timeout_err_d;
            step_pending_q <= step_pending_d;
            step_btn_q     <= bus.step_btn;
            pe_step_q      <= (state_d == SNAP);
            pe_load_q      <= (state_d == LOAD);
        end
    end

    assign bus.pe_step     = pe_step_q;
    assign bus.pe_load     = pe_load_q;
    assign bus.alive_prev  = alive_prev_q;
    assign bus.gen_count   = gen_count_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler: run pacing, step collapse, partial done, timeout, load, wrap.
module tb_life_gen_scheduler;
    localparam int FPG = 3;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    life_gen_if bus();

    life_gen_scheduler #(.FRAMES_PER_GEN(FPG), .TIMEOUT_CYCLES(TMO), .NUM_ARRAYS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    task automatic done(input logic [3:0] m);
        bus.pe_done = m;
        tick();
        bus.pe_done = 4'h0;
    endtask

    task automatic press();
        bus.step_btn = 1'b1;
        tick();
        bus.step_btn = 1'b0;
        tick();
    endtask

    task automatic load();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        tick();
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.run        = 1'b0;
        bus.step_btn   = 1'b0;
        bus.load_req   = 1'b0;
        bus.pe_done    = 4'h0;
        bus.alive_in   = 64'h0;
        repeat (3) tick();
        check("rst_pe_step", bus.pe_step, 0);
        check("rst_pe_load", bus.pe_load, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gen", bus.gen_count, 0);
        check("rst_prev", bus.alive_prev, 0);
        check("rst_terr", bus.timeout_err, 0);

        // run mode: one step per FPG frame ticks
        rst = 1'b0;
        bus.run = 1'b1;
        tick();
        check("t1_arm_busy", bus.busy, 1);
        frame();
        check("t1_f1", bus.pe_step, 0);
        frame();
        check("t1_f2", bus.pe_step, 0);
        frame();
        check("t1_snap", bus.pe_step, 1);
        tick();
        check("t1_pulse", bus.pe_step, 0);
        repeat (3) tick();
        done(4'hF);
        check("t1_gen1", bus.gen_count, 1);
        check("t1_idle", bus.busy, 0);
        tick();
        frame();
        frame();
        frame();
        check("t1_snap2", bus.pe_step, 1);
        bus.run = 1'b0;
        tick();
        // two step edges while busy collapse into one pending request
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0; tick();
        bus.step_btn = 1'b1; tick();
        bus.step_btn = 1'b0; tick();
        done(4'hF);
        check("t1_gen2", bus.gen_count, 2);
        check("t1_idle2", bus.busy, 0);

        tick();
        check("t2_arm", bus.busy, 1);
        check("t2_nostep", bus.pe_step, 0);
        frame();
        check("t2_step", bus.pe_step, 1);
        tick();
        done(4'hF);
        check("t2_gen3", bus.gen_count, 3);
        repeat (4) tick();
        check("t2_collapse_busy", bus.busy, 0);
        check("t2_collapse_step", bus.pe_step, 0);

        // done bits on separate cycles
        press();
        frame();
        tick();
        done(4'h1);
        done(4'h2);
        done(4'h4);
        tick();
        tick();
        check("t3_partial_busy", bus.busy, 1);
        check("t3_partial_gen", bus.gen_count, 3);
        done(4'h8);
        check("t3_gen4", bus.gen_count, 4);
        check("t3_idle", bus.busy, 0);

        // timeout with array 3 silent
        press();
        frame();
        tick();
        done(4'h7);
        repeat (14) tick();
        check("t4_pre_busy", bus.busy, 1);
        check("t4_pre_terr", bus.timeout_err, 0);
        tick();
        check("t4_busy", bus.busy, 0);
        check("t4_terr", bus.timeout_err, 1);
        check("t4_gen", bus.gen_count, 4);
        bus.load_req = 1'b1;
        tick();
        check("t4_pe_load", bus.pe_load, 1);
        bus.load_req = 1'b0;
        tick();
        check("t4_load_off", bus.pe_load, 0);
        check("t4_terr_clr", bus.timeout_err, 0);
        check("t4_gen_clr", bus.gen_count, 0);

        // snapshot and load clear
        bus.alive_in = 64'h0000_0000_0000_0660;
        press();
        frame();
        check("t5_prev_before", bus.alive_prev, 0);
        tick();
        check("t5_prev", bus.alive_prev, 64'h660);
        done(4'hF);
        check("t5_gen", bus.gen_count, 1);
        load();
        check("t5_prev_clr", bus.alive_prev, 0);
        check("t5_gen_clr", bus.gen_count, 0);

        // frame_cnt held across a run pause
        bus.run = 1'b1;
        tick();
        frame();
        bus.run = 1'b0;
        tick();
        check("t5_pause_idle", bus.busy, 0);
        bus.run = 1'b1;
        tick();
        frame();
        check("t5_hold_f2", bus.pe_step, 0);
        frame();
        check("t5_hold_snap", bus.pe_step, 1);
        bus.run = 1'b0;
        tick();
        done(4'hF);
        check("t5_hold_gen", bus.gen_count, 1);

        // generation counter wrap
        force dut.gen_count_q = 16'hFFFF;
        tick();
        release dut.gen_count_q;
        tick();
        check("t6_preset", bus.gen_count, 16'hFFFF);
        press();
        frame();
        tick();
        done(4'hF);
        check("t6_wrap", bus.gen_count, 0);

`ifdef STILL_LIFE_HALT_EN
        begin
            logic saw;
            load();
            bus.run = 1'b1;
            tick();
            frame();
            frame();
            frame();
            tick();
            done(4'hF);
            check("t6_halt_gen", bus.gen_count, 1);
            repeat (3) tick();
            check("t6_halted", bus.halted, 1);
            check("t6_halt_idle", bus.busy, 0);
            saw = 1'b0;
            repeat (4) begin
                frame();
                saw |= bus.pe_step;
            end
            check("t6_halt_nostep", saw, 0);
            bus.run = 1'b0;
            tick();
            tick();
            check("t6_unhalt", bus.halted, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
